// File: rtl/rv32_load_store_unit.sv
// rv32_load_store_unit
//   Executes one RV32I load or store at a time against a simple
//   request/ready memory port, then writes load results to the register file.
//
// Parameters
//   MEM_TIMEOUT  maximum REQ cycles without mem_ready before the op faults
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               launch an op (sampled only while idle)
//   is_store, funct3    op kind and RV32I width/sign code
//   base, offset        effective address operands (ea = base + offset)
//   store_data, rd      rs2 value, destination register index
//   busy, done, fault   status; done pulses one cycle, fault qualifies done
//   mem_req, mem_we     memory request valid / write
//   mem_addr            word-aligned address
//   mem_wdata/wmask     lane-replicated store data and byte enables
//   mem_ready/rdata     memory handshake and read data
//   rf_we, rf_a3        register-file write enable / address
//   rf_wdata            sign/zero-extended load result
module rv32_load_store_unit #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] base,
   input  logic [31:0] offset,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        rf_we,
   output logic [4:0]  rf_a3,
   output logic [31:0] rf_wdata
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 2);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WB,
      SDONE,
      FAULT
   } state_t;

   state_t         state_q, state_d;
   logic           is_store_q;
   logic [2:0]     funct3_q;
   logic [4:0]     rd_q;
   logic [31:0]    sdata_q;
   logic [31:0]    ea_q;
   logic [31:0]    rdata_q;
   logic [CW-1:0]  wait_q;

   logic [31:0]    ea_in;
   logic           op_legal;
   logic           misaligned;
   logic [CW-1:0]  wait_inc;
   logic           timeout_hit;
   logic [31:0]    shifted;
   logic [31:0]    load_val;
   logic [31:0]    st_wdata;
   logic [3:0]     st_mask;

   // Decode of the launching op, evaluated from the live inputs in IDLE
   always_comb begin
      ea_in = base + offset;
      if (is_store)
         op_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else
         op_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
      misaligned = ((funct3[1:0] == 2'b01) && ea_in[0]) ||
                   ((funct3[1:0] == 2'b10) && (ea_in[1:0] != 2'b00));
   end

   // Timeout fires on the MEM_TIMEOUT-th REQ cycle that lacks mem_ready
   always_comb begin
      wait_inc    = wait_q + 1'b1;
      timeout_hit = (wait_inc >= CW'(MEM_TIMEOUT));
   end

   // Load extraction: shift the addressed lane down, then extend by funct3
   always_comb begin
      shifted = mem_rdata >> {ea_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_val = {24'd0, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_val = {16'd0, shifted[15:0]};
         default: load_val = mem_rdata;
      endcase
   end

   // Store lanes: data replicated across the word, mask selects the lanes
   always_comb begin
      case (funct3_q[1:0])
         2'b00: begin
            st_mask  = 4'b0001 << ea_q[1:0];
            st_wdata = {4{sdata_q[7:0]}};
         end
         2'b01: begin
            st_mask  = 4'b0011 << ea_q[1:0];
            st_wdata = {2{sdata_q[15:0]}};
         end
         default: begin
            st_mask  = 4'b1111;
            st_wdata = sdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         funct3_q   <= '0;
         rd_q       <= '0;
         sdata_q    <= '0;
         ea_q       <= '0;
         rdata_q    <= '0;
         wait_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            wait_q <= '0;
            if (start) begin
               is_store_q <= is_store;
               funct3_q   <= funct3;
               rd_q       <= rd;
               sdata_q    <= store_data;
               ea_q       <= ea_in;
            end
         end else if (state_q == REQ) begin
            if (mem_ready) begin
               if (!is_store_q)
                  rdata_q <= load_val;
            end else begin
               wait_q <= wait_inc;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      busy      = (state_q != IDLE);
      done      = 1'b0;
      fault     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      rf_we     = 1'b0;
      rf_a3     = '0;
      rf_wdata  = '0;
      case (state_q)
         IDLE: begin
            if (start)
               state_d = (!op_legal || misaligned) ? FAULT : REQ;
         end
         REQ: begin
            mem_req  = 1'b1;
            mem_we   = is_store_q;
            mem_addr = {ea_q[31:2], 2'b00};
            if (is_store_q) begin
               mem_wdata = st_wdata;
               mem_wmask = st_mask;
            end
            if (mem_ready)
               state_d = is_store_q ? SDONE : WB;
            else if (timeout_hit)
               state_d = FAULT;
         end
         WB: begin
            done     = 1'b1;
            rf_we    = (rd_q != 5'd0);
            rf_a3    = rd_q;
            rf_wdata = rdata_q;
            state_d  = IDLE;
         end
         SDONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         FAULT: begin
            done    = 1'b1;
            fault   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Testbench for rv32_load_store_unit: a reference model pushes the expected
// outcome of every launched op into a queue; the result is popped and
// compared when the unit signals done.
module tb_rv32_load_store_unit;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] base = '0;
   logic [31:0] offset = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  rd = '0;
   logic        busy, done, fault, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wdata;
   logic [110:0] outs;

   int checks = 0;
   int errors = 0;

   // res  = {fault, rf_we, rf_a3, rf_wdata}
   // mreq = {mem_req, mem_addr, mem_we, mem_wdata, mem_wmask} seen in REQ
   typedef struct {
      logic [38:0] res;
      logic [69:0] mreq;
      int unsigned lat;
   } exp_t;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] b;
      logic [31:0] o;
      logic [31:0] sd;
      logic [4:0]  r;
      int unsigned w;
      logic [31:0] rdat;
      string       name;
   } op_t;

   exp_t sb[$];

   rv32_load_store_unit #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store),
      .funct3(funct3), .base(base), .offset(offset), .store_data(store_data),
      .rd(rd), .busy(busy), .done(done), .fault(fault), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wdata(rf_wdata)
   );

   assign outs = {busy, done, fault, mem_req, mem_we, mem_addr, mem_wdata,
                  mem_wmask, rf_we, rf_a3, rf_wdata};

   always #5 clk = ~clk;

   function automatic exp_t model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] b, input logic [31:0] o,
                                  input logic [31:0] sd, input logic [4:0] r,
                                  input int unsigned waits, input logic [31:0] rdat);
      exp_t        e;
      logic [31:0] ea;
      logic        legal, mis;
      logic [7:0]  by;
      logic [15:0] hw;
      logic [31:0] val;
      logic [3:0]  mask;
      logic [31:0] wd;
      ea    = b + o;
      legal = st ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      mis   = ((f3[1:0] == 2'b01) && ea[0]) || ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
      e.res  = '0;
      e.mreq = '0;
      e.lat  = 0;
      if (!legal || mis) begin
         e.res = {1'b1, 38'd0};
         e.lat = 1;
         return e;
      end
      mask = '0;
      wd   = '0;
      if (st) begin
         for (int i = 0; i < 4; i++) begin
            case (f3[1:0])
               2'b00:   mask[i] = (i == int'(ea[1:0]));
               2'b01:   mask[i] = ((i / 2) == int'(ea[1]));
               default: mask[i] = 1'b1;
            endcase
         end
         wd = (f3[1:0] == 2'b00) ? {4{sd[7:0]}} : (f3[1:0] == 2'b01) ? {2{sd[15:0]}} : sd;
      end
      e.mreq = {1'b1, ea[31:2], 2'b00, st, wd, mask};
      if (waits >= TO) begin
         e.res = {1'b1, 38'd0};
         e.lat = TO + 1;
         return e;
      end
      e.lat = waits + 2;
      if (!st) begin
         by = rdat[8*ea[1:0] +: 8];
         hw = ea[1] ? rdat[31:16] : rdat[15:0];
         case (f3)
            3'b000:  val = {{24{by[7]}}, by};
            3'b100:  val = {24'd0, by};
            3'b001:  val = {{16{hw[15]}}, hw};
            3'b101:  val = {16'd0, hw};
            default: val = rdat;
         endcase
         e.res = {1'b0, (r != 5'd0), r, val};
      end
      return e;
   endfunction

   // Launches one op (called at a falling edge), plays the memory side and
   // returns what the unit produced. hold keeps start high with scrambled
   // operands while busy, which the unit must ignore.
   task automatic run_op(input op_t op, input bit hold, output exp_t obs,
                         output bit stable, output bit idle_after);
      bit          first;
      int unsigned wl;
      is_store   = op.st;
      funct3     = op.f3;
      base       = op.b;
      offset     = op.o;
      store_data = op.sd;
      rd         = op.r;
      start      = 1'b1;
      sb.push_back(model(op.st, op.f3, op.b, op.o, op.sd, op.r, op.w, op.rdat));
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      base       = $urandom;
      offset     = $urandom;
      store_data = $urandom;
      rd         = 5'($urandom);
      funct3     = 3'($urandom);
      is_store   = 1'($urandom);
      obs.res  = '0;
      obs.mreq = '0;
      obs.lat  = 0;
      stable   = 1'b1;
      first    = 1'b1;
      wl       = op.w;
      for (int unsigned cyc = 1; cyc <= 50; cyc++) begin
         if (mem_req) begin
            if (first)
               obs.mreq = {mem_req, mem_addr, mem_we, mem_wdata, mem_wmask};
            else if ({mem_req, mem_addr, mem_we, mem_wdata, mem_wmask} !== obs.mreq)
               stable = 1'b0;
            first = 1'b0;
            if (wl == 0) begin
               mem_ready = 1'b1;
               mem_rdata = op.rdat;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
               wl--;
            end
         end else begin
            mem_ready = 1'b0;
         end
         if (done) begin
            obs.res = {fault, rf_we, rf_a3, rf_wdata};
            obs.lat = cyc;
            start   = 1'b0;
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      mem_ready = 1'b0;
      start     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      idle_after = !busy && !done && !mem_req && !rf_we;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_hold: outputs %h required 0", outs);
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL post_reset_quiet[%0d]: outputs %h required 0", i, outs);
         end
      end
   endtask

   task automatic test_loads();
      op_t  ops[$];
      exp_t obs, e;
      bit   stable, idle_after;
      ops.push_back('{1'b0, 3'b010, 32'h100, 32'd4, 32'h0, 5'd5, 0, 32'hDEADBEEF, "lw_basic"});
      ops.push_back('{1'b0, 3'b000, 32'h200, 32'd3, 32'h0, 5'd7, 0, 32'h80112233, "lb_sign"});
      ops.push_back('{1'b0, 3'b100, 32'h200, 32'd3, 32'h0, 5'd8, 0, 32'h80112233, "lbu_zero"});
      ops.push_back('{1'b0, 3'b001, 32'h400, 32'd2, 32'h0, 5'd9, 1, 32'h80011234, "lh_sign"});
      ops.push_back('{1'b0, 3'b101, 32'h400, 32'd0, 32'h0, 5'd10, 0, 32'h1234F00D, "lhu_zero"});
      ops.push_back('{1'b0, 3'b000, 32'h0, 32'd1, 32'h0, 5'd11, 2, 32'h00007F00, "lb_lane1"});
      ops.push_back('{1'b0, 3'b010, 32'h800, 32'd0, 32'h0, 5'd0, 0, 32'h00000055, "lw_rd0"});
      ops.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'd8, 32'h0, 5'd31, 3, 32'hCAFEF00D, "lw_wrap_wait3"});
      foreach (ops[k]) begin
         run_op(ops[k], 1'b0, obs, stable, idle_after);
         e = sb.pop_front();
         checks++;
         if (obs.res !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h required %h", ops[k].name, obs.res, e.res);
         end
         checks++;
         if (obs.lat != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", ops[k].name, obs.lat, e.lat);
         end
         checks++;
         if (obs.mreq !== e.mreq) begin
            errors++;
            $display("FAIL %s request: got %h required %h", ops[k].name, obs.mreq, e.mreq);
         end
         checks++;
         if (!stable || !idle_after) begin
            errors++;
            $display("FAIL %s hold/idle: got %b%b required 11", ops[k].name, stable, idle_after);
         end
      end
   endtask

   task automatic test_stores();
      op_t  ops[$];
      exp_t obs, e;
      bit   stable, idle_after;
      for (int i = 0; i < 4; i++)
         ops.push_back('{1'b1, 3'b000, 32'h500, 32'(i), 32'h12345678, 5'd3, 0, 32'h0, "sb_lane"});
      ops.push_back('{1'b1, 3'b001, 32'h300, 32'd2, 32'h0000ABCD, 5'd4, 3, 32'h0, "sh_upper_wait3"});
      ops.push_back('{1'b1, 3'b001, 32'h300, 32'd0, 32'h9876ABCD, 5'd4, 0, 32'h0, "sh_lower"});
      ops.push_back('{1'b1, 3'b010, 32'h5FC, 32'd4, 32'hA5A55A5A, 5'd6, 1, 32'h0, "sw_wait1"});
      foreach (ops[k]) begin
         run_op(ops[k], 1'b0, obs, stable, idle_after);
         e = sb.pop_front();
         checks++;
         if (obs.res !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h required %h", ops[k].name, obs.res, e.res);
         end
         checks++;
         if (obs.lat != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", ops[k].name, obs.lat, e.lat);
         end
         checks++;
         if (obs.mreq !== e.mreq) begin
            errors++;
            $display("FAIL %s request: got %h required %h", ops[k].name, obs.mreq, e.mreq);
         end
         checks++;
         if (!stable || !idle_after) begin
            errors++;
            $display("FAIL %s hold/idle: got %b%b required 11", ops[k].name, stable, idle_after);
         end
      end
   endtask

   task automatic test_faults();
      op_t  ops[$];
      exp_t obs, e;
      bit   stable, idle_after;
      ops.push_back('{1'b0, 3'b010, 32'h100, 32'd1, 32'h0, 5'd5, 0, 32'h0, "lw_misaligned"});
      ops.push_back('{1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 5'd5, 0, 32'h0, "ld_f3_011"});
      ops.push_back('{1'b0, 3'b110, 32'h100, 32'd0, 32'h0, 5'd5, 0, 32'h0, "ld_f3_110"});
      ops.push_back('{1'b0, 3'b101, 32'h0FF, 32'd2, 32'h0, 5'd5, 0, 32'h0, "lhu_misaligned"});
      ops.push_back('{1'b1, 3'b010, 32'h100, 32'd2, 32'h0, 5'd0, 0, 32'h0, "sw_misaligned"});
      ops.push_back('{1'b1, 3'b100, 32'h100, 32'd0, 32'h0, 5'd0, 0, 32'h0, "st_f3_100"});
      ops.push_back('{1'b0, 3'b010, 32'h100, 32'd0, 32'h0, 5'd5, 100, 32'h0, "lw_timeout"});
      ops.push_back('{1'b1, 3'b000, 32'h100, 32'd1, 32'hFF, 5'd0, TO, 32'h0, "sb_timeout_edge"});
      foreach (ops[k]) begin
         run_op(ops[k], 1'b0, obs, stable, idle_after);
         e = sb.pop_front();
         checks++;
         if (obs.res !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h required %h", ops[k].name, obs.res, e.res);
         end
         checks++;
         if (obs.lat != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", ops[k].name, obs.lat, e.lat);
         end
         checks++;
         if (obs.mreq !== e.mreq) begin
            errors++;
            $display("FAIL %s request: got %h required %h", ops[k].name, obs.mreq, e.mreq);
         end
         checks++;
         if (!stable || !idle_after) begin
            errors++;
            $display("FAIL %s hold/idle: got %b%b required 11", ops[k].name, stable, idle_after);
         end
      end
   endtask

   task automatic test_back_to_back();
      op_t  op;
      exp_t obs, e;
      bit   stable, idle_after;
      for (int k = 0; k < 30; k++) begin
         op.st   = 1'($urandom);
         op.f3   = 3'($urandom_range(0, 7));
         op.b    = $urandom;
         op.o    = 32'($urandom_range(0, 7));
         op.sd   = $urandom;
         op.r    = 5'($urandom);
         op.w    = $urandom_range(0, 5);
         op.rdat = $urandom;
         op.name = "random";
         run_op(op, (k % 2) == 1, obs, stable, idle_after);
         e = sb.pop_front();
         checks++;
         if (obs.res !== e.res) begin
            errors++;
            $display("FAIL random[%0d] result: got %h required %h", k, obs.res, e.res);
         end
         checks++;
         if (obs.lat != e.lat) begin
            errors++;
            $display("FAIL random[%0d] latency: got %0d required %0d", k, obs.lat, e.lat);
         end
         checks++;
         if (obs.mreq !== e.mreq) begin
            errors++;
            $display("FAIL random[%0d] request: got %h required %h", k, obs.mreq, e.mreq);
         end
         checks++;
         if (!stable || !idle_after) begin
            errors++;
            $display("FAIL random[%0d] hold/idle: got %b%b required 11", k, stable, idle_after);
         end
      end
   endtask

   task automatic test_reset_mid_req();
      is_store = 1'b0;
      funct3   = 3'b010;
      base     = 32'h700;
      offset   = 32'h0;
      rd       = 5'd3;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin
         errors++;
         $display("FAIL mid_req_pending: got %h required %h", {mem_req, mem_addr}, {1'b1, 32'h700});
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL mid_req_reset: outputs %h required 0", outs);
      end
      reset     = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h11111111;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL late_ready_ignored[%0d]: outputs %h required 0", i, outs);
         end
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_loads();
      test_stores();
      test_faults();
      test_back_to_back();
      test_reset_mid_req();
      test_loads();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32_load_store_unit.md
RV32_LOAD_STORE_UNIT -- requirements
Module: rv32_load_store_unit

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 255, meaning max REQ-state cycles waiting for mem_ready before fault.
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, launch op; sampled only in IDLE.
- is_store, in, 1, 1=store, 0=load.
- funct3, in, 3, RV32I width/sign code.
- base, in, 32, rs1 value from register file.
- offset, in, 32, sign-extended immediate.
- store_data, in, 32, rs2 value from register file.
- rd, in, 5, destination register index.
- busy, out, 1, state != IDLE.
- done, out, 1, one-cycle completion pulse.
- fault, out, 1, valid with done; misaligned, illegal funct3 or timeout.
- mem_req, out, 1, memory request valid.
- mem_we, out, 1, request is a write.
- mem_addr, out, 32, word address; bits[1:0] always 0.
- mem_wdata, out, 32, lane-replicated store data.
- mem_wmask, out, 4, byte write enables.
- mem_ready, in, 1, memory accepts/completes request this cycle.
- mem_rdata, in, 32, read data; valid when mem_ready=1 on a read.
- rf_we, out, 1, register-file write enable.
- rf_a3, out, 5, register-file write address.
- rf_wdata, out, 32, register-file write data.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WB, SDONE, FAULT; busy=1 in every state except IDLE.
REQ-004 In IDLE with start=1, SHALL latch is_store, funct3, rd, store_data and ea=base+offset (mod 2^32, carry discarded); start outside IDLE SHALL be ignored.
REQ-005 Legal funct3 SHALL be loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU and stores 000 SB, 001 SH, 010 SW; any other code SHALL go IDLE->FAULT.
REQ-006 Misalignment (halfword with ea[0]=1, word with ea[1:0]!=0) SHALL go IDLE->FAULT with no memory request; otherwise IDLE->REQ.
REQ-007 In REQ, mem_req=1 and mem_addr={ea[31:2],2'b00}, mem_we, mem_wdata, mem_wmask SHALL stay constant until mem_ready=1 is sampled.
REQ-008 Store lanes: SB mask=4'b0001<<ea[1:0], wdata={4{data[7:0]}}; SH mask=4'b0011<<ea[1:0], wdata={2{data[15:0]}}; SW mask=4'b1111, wdata=data; loads SHALL drive mask=0, we=0.
REQ-009 REQ with mem_ready=1 SHALL go to WB for loads, capturing mem_rdata, and to SDONE for stores.
REQ-010 A wait counter SHALL clear on IDLE->REQ and increment each REQ cycle without mem_ready; after MEM_TIMEOUT such cycles, REQ SHALL go to FAULT.
REQ-011 Load extraction: byte=rdata>>(8*ea[1:0]), half=rdata>>(8*ea[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-012 WB SHALL last one cycle with rf_we=(rd!=0), rf_a3=rd, rf_wdata=extracted value, done=1, then go to IDLE.
REQ-013 SDONE and FAULT SHALL each last one cycle with done=1 (fault=1 in FAULT only) and rf_we=0, then go to IDLE.
REQ-014 Zero-wait latency SHALL be exactly 2 cycles from start sampled to done; each REQ cycle without mem_ready adds one cycle.
REQ-015 Outside WB, rf_we SHALL be 0 and rf_a3/rf_wdata SHALL be 0; outside REQ, mem_req=0 and all mem_* outputs SHALL be 0.

Reset
REQ-016 Reset sampled high SHALL force IDLE, clear the wait counter and latches, and zero all outputs from the next cycle, including mid-REQ; a late mem_ready SHALL be ignored.
REQ-017 No output SHALL pulse in the cycle after reset deasserts unless start is given.

Verification
REQ-018 LW: base=0x100, offset=4, rd=5, mem_rdata=0xDEADBEEF with mem_ready on first REQ cycle -> mem_addr=0x104; 2 cycles later rf_we=1, rf_a3=5, rf_wdata=0xDEADBEEF, done=1.
REQ-019 LB/LBU: ea=0x203, rdata=0x80112233 -> LB writes 0xFFFFFF80, LBU writes 0x00000080.
REQ-020 SH: ea=0x302, store_data=0x0000ABCD, 3 wait cycles -> mem_wmask=4'b1100, mem_wdata=0xABCDABCD held 4 cycles; done 5 cycles after start; rf_we=0.
REQ-021 LW with ea=0x101 -> no mem_req; done=1, fault=1 one cycle after start; funct3=011 behaves identically.
REQ-022 MEM_TIMEOUT=4, mem_ready stuck at 0 -> fault after 4 REQ cycles; reset asserted mid-REQ in a second run -> mem_req=0 and busy=0 the cycle after.
